game_state_fsm: RTL and testbench

Top-level game sequencer for the obstacle game, directly upstream of the obstacle scroll counter. Generates the `menuScreen`, `playerWon` and `playerLost` level-control signals that hold the scroll counter and game timer cleared. Consumes the counter's `obj_position_counter` to count completed obstacle passes (laps) and the collision flag from the collision checker. Decides win/loss, then returns to the menu after a timed result screen.

---
 rtl/game_pkg.sv | 22 ++
 rtl/game_state_fsm_if.sv | 25 ++
 rtl/game_state_fsm_rise_edge.sv | 22 ++
 rtl/game_state_fsm.sv | 153 +++++++++++++++
 tb/tb_game_state_fsm.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle-game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } game_state_t;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned LAP_W   = 8;
  localparam int unsigned LIVES_W = 4;
  localparam int unsigned HOLD_W  = 16;
  localparam int unsigned GRACE_W = 16;

  localparam int unsigned DEF_LAPS_TO_WIN = 8;
  localparam int unsigned DEF_RESULT_HOLD = 180;
  localparam int unsigned DEF_LIVES       = 3;
  localparam int unsigned DEF_GRACE_TICKS = 60;

endpackage

// File: rtl/game_state_fsm_if.sv
// Control/status bundle between the game sequencer and its neighbours.
interface game_state_fsm_if
  import game_pkg::*;
();

  logic               start;
  logic               collision;
  logic [POS_W-1:0]   obj_position_counter;
  logic               menuScreen;
  logic               playerWon;
  logic               playerLost;
  logic [LAP_W-1:0]   lap_count;
  logic [LIVES_W-1:0] lives_left;

  modport master (
    output start, collision, obj_position_counter,
    input  menuScreen, playerWon, playerLost, lap_count, lives_left
  );

  modport slave (
    input  start, collision, obj_position_counter,
    output menuScreen, playerWon, playerLost, lap_count, lives_left
  );

endinterface

// File: rtl/game_state_fsm_rise_edge.sv
// Registered rising-edge detector; reset value of the history flop is configurable
// so a level held through reset can be made to look "already high".
module rise_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  // History flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) d_q <= RST_VAL;
    else       d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/game_state_fsm.sv
// Game sequencer: MENU -> PLAY -> WON/LOST -> MENU, with lap counting.
// Optional feature macro: GAME_LIVES_EN (multiple lives with a post-hit grace window).
module game_state_fsm
  import game_pkg::*;
#(
  parameter int unsigned LAPS_TO_WIN = DEF_LAPS_TO_WIN,
  parameter int unsigned RESULT_HOLD = DEF_RESULT_HOLD,
  parameter int unsigned LIVES       = DEF_LIVES,
  parameter int unsigned GRACE_TICKS = DEF_GRACE_TICKS
) (
  input logic             clk,
  input logic             reset,
  game_state_fsm_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);
  localparam logic [LAP_W-1:0]  LAP_WIN   = LAP_W'(LAPS_TO_WIN);
  localparam logic [LAP_W-1:0]  LAP_MAX   = '1;

  // Elaboration-time range check on the configuration.
  if (LAPS_TO_WIN < 1 || LAPS_TO_WIN > 255 || RESULT_HOLD < 1 || RESULT_HOLD > 65535 ||
      LIVES < 1 || LIVES > 15 || GRACE_TICKS < 1 || GRACE_TICKS > 65535) begin : g_bad_cfg
    $error("game_state_fsm: parameter out of range");
  end

  game_state_t        state;
  logic               menu_screen;
  logic               player_won;
  logic               player_lost;
  logic [LAP_W-1:0]   lap_count;
  logic [POS_W-1:0]   prev_pos;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               start_rise_c;
  logic               lap_seen_c;
  logic [LAP_W-1:0]   lap_inc_c;
  logic               win_c;
  logic               lose_c;

`ifdef GAME_LIVES_EN
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [GRACE_W-1:0] GRACE_INIT = GRACE_W'(GRACE_TICKS);
  logic [LIVES_W-1:0] lives_left;
  logic [GRACE_W-1:0] grace_cnt;
  logic               hit_c;
`endif

  // Start button edge; history resets high so a held button never auto-starts.
  rise_edge #(.RST_VAL(1'b1)) u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .d      (bus.start),
    .rise_c (start_rise_c)
  );

  // Lap detection and win/lose decisions for the PLAY state.
  always_comb begin
    lap_seen_c = bus.obj_position_counter < prev_pos;
    lap_inc_c  = (lap_count == LAP_MAX) ? lap_count : lap_count + LAP_W'(1);
    win_c      = lap_seen_c && (lap_inc_c == LAP_WIN);
`ifdef GAME_LIVES_EN
    hit_c      = bus.collision && (grace_cnt == '0);
    lose_c     = hit_c && (lives_left <= LIVES_W'(1));
`else
    lose_c     = bus.collision;
`endif
  end

  // Sequencer state, registered control outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= MENU;
      menu_screen <= 1'b1;
      player_won  <= 1'b0;
      player_lost <= 1'b0;
      lap_count   <= '0;
      prev_pos    <= '0;
      hold_cnt    <= '0;
`ifdef GAME_LIVES_EN
      lives_left  <= LIVES_INIT;
      grace_cnt   <= '0;
`endif
    end else begin
      case (state)
        MENU: begin
          if (start_rise_c) begin
            state       <= PLAY;
            menu_screen <= 1'b0;
            prev_pos    <= '0;
            lap_count   <= '0;
`ifdef GAME_LIVES_EN
            grace_cnt   <= '0;
`endif
          end
        end

        PLAY: begin
          prev_pos <= bus.obj_position_counter;
          if (lap_seen_c) lap_count <= lap_inc_c;
`ifdef GAME_LIVES_EN
          if (grace_cnt != '0) begin
            grace_cnt <= grace_cnt - GRACE_W'(1);
          end else if (hit_c) begin
            lives_left <= lives_left - LIVES_W'(1);
            grace_cnt  <= GRACE_INIT;
          end
`endif
          if (lose_c) begin
            state       <= LOST;
            player_lost <= 1'b1;
            hold_cnt    <= '0;
          end else if (win_c) begin
            state      <= WON;
            player_won <= 1'b1;
            hold_cnt   <= '0;
          end
        end

        WON, LOST: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (start_rise_c || hold_cnt == HOLD_LAST) begin
            state       <= MENU;
            menu_screen <= 1'b1;
            player_won  <= 1'b0;
            player_lost <= 1'b0;
            lap_count   <= '0;
`ifdef GAME_LIVES_EN
            lives_left  <= LIVES_INIT;
`endif
          end
        end

        default: begin
          state       <= MENU;
          menu_screen <= 1'b1;
          player_won  <= 1'b0;
          player_lost <= 1'b0;
          lap_count   <= '0;
        end
      endcase
    end
  end

  assign bus.menuScreen = menu_screen;
  assign bus.playerWon  = player_won;
  assign bus.playerLost = player_lost;
  assign bus.lap_count  = lap_count;
`ifdef GAME_LIVES_EN
  assign bus.lives_left = lives_left;
`else
  assign bus.lives_left = '0;
`endif

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed self-checking bench for game_state_fsm (both macro settings).
module tb_game_state_fsm;

  localparam int unsigned HOLD = 12;
`ifdef GAME_LIVES_EN
  localparam int EXP_LIVES = 3;
`else
  localparam int EXP_LIVES = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  game_state_fsm_if bus ();

  game_state_fsm #(
    .LAPS_TO_WIN (8),
    .RESULT_HOLD (HOLD),
    .LIVES       (3),
    .GRACE_TICKS (60)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input int m, input int w, input int l);
    check({tag, ".menu"}, int'(bus.menuScreen), m);
    check({tag, ".won"},  int'(bus.playerWon),  w);
    check({tag, ".lost"}, int'(bus.playerLost), l);
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // One lap: position 10..690 then wrap to 0 (optionally colliding on the wrap).
  task automatic run_lap(input logic coll_on_wrap);
    for (int i = 1; i < 70; i++) begin
      bus.obj_position_counter = 10'(i * 10);
      tick();
    end
    bus.obj_position_counter = '0;
    bus.collision = coll_on_wrap;
    tick();
    bus.collision = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b1;
    bus.collision = 1'b0;
    bus.obj_position_counter = '0;
    tick();
    tick();
    check_flags("reset", 1, 0, 0);
    check("reset.lap", int'(bus.lap_count), 0);
    check("reset.lives", int'(bus.lives_left), EXP_LIVES);
    reset = 1'b0;

    // Start held through reset must not launch a game.
    repeat (10) tick();
    check_flags("held_start", 1, 0, 0);
    bus.start = 1'b0;
    tick();
    press_start();
    check_flags("play_entry", 0, 0, 0);

    // Game 1: eight clean laps -> WON, then timed return to MENU.
    repeat (7) run_lap(1'b0);
    check("g1.lap7", int'(bus.lap_count), 7);
    check_flags("g1.lap7", 0, 0, 0);
    run_lap(1'b0);
    check_flags("g1.win", 0, 1, 0);
    check("g1.win.lap", int'(bus.lap_count), 8);
    repeat (HOLD - 1) tick();
    check_flags("g1.hold_end", 0, 1, 0);
    check("g1.hold_end.lap", int'(bus.lap_count), 8);
    tick();
    check_flags("g1.menu", 1, 0, 0);
    check("g1.menu.lap", int'(bus.lap_count), 0);

    // Game 2: collision at lap 3.
    press_start();
    check_flags("g2.entry", 0, 0, 0);
    repeat (3) run_lap(1'b0);
    check("g2.lap3", int'(bus.lap_count), 3);
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
`ifdef GAME_LIVES_EN
    check("g2.hit1.lives", int'(bus.lives_left), 2);
    check_flags("g2.hit1", 0, 0, 0);
    repeat (9) tick();
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    check("g2.grace.lives", int'(bus.lives_left), 2);
    repeat (59) tick();
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    check("g2.hit2.lives", int'(bus.lives_left), 1);
    check_flags("g2.hit2", 0, 0, 0);
    repeat (69) tick();
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    check("g2.hit3.lives", int'(bus.lives_left), 0);
`endif
    check_flags("g2.lost", 0, 0, 1);
    check("g2.lost.lap", int'(bus.lap_count), 3);
    press_start();
    check_flags("g2.start_exit", 1, 0, 0);
    check("g2.start_exit.lap", int'(bus.lap_count), 0);
    check("g2.start_exit.lives", int'(bus.lives_left), EXP_LIVES);

    // Game 3: winning wrap coincides with a collision.
    tick();
    press_start();
    repeat (7) run_lap(1'b0);
    run_lap(1'b1);
`ifdef GAME_LIVES_EN
    check_flags("g3.tie", 0, 1, 0);
    check("g3.tie.lives", int'(bus.lives_left), 2);
`else
    check_flags("g3.tie", 0, 0, 1);
`endif
    check("g3.tie.lap", int'(bus.lap_count), 8);
    press_start();
    check_flags("g3.exit", 1, 0, 0);

    // Game 4: reset in the middle of the WON hold.
    tick();
    press_start();
    repeat (8) run_lap(1'b0);
    check_flags("g4.win", 0, 1, 0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_flags("g4.reset", 1, 0, 0);
    check("g4.reset.lap", int'(bus.lap_count), 0);
    check("g4.reset.lives", int'(bus.lives_left), EXP_LIVES);

    // Game 5: full hold period again after the reset.
    tick();
    press_start();
    check_flags("g5.entry", 0, 0, 0);
    repeat (8) run_lap(1'b0);
    check_flags("g5.win", 0, 1, 0);
    repeat (HOLD - 1) tick();
    check_flags("g5.hold_end", 0, 1, 0);
    tick();
    check_flags("g5.menu", 1, 0, 0);
    check("g5.menu.lap", int'(bus.lap_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
